// File: rtl/term_pkg.sv
// Shared constants, control codes and state encoding for the text-mode terminal front end.
package term_pkg;

  localparam int unsigned DEF_COLS     = 80;
  localparam int unsigned DEF_ROWS     = 30;
  localparam int unsigned DEF_X_W      = 7;
  localparam int unsigned DEF_Y_W      = 5;
  localparam int unsigned DEF_TAB_STOP = 8;

  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_TAB      = 8'h09;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_ESC      = 8'h1B;
  localparam logic [7:0] CH_LBRACKET = 8'h5B;
  localparam logic [7:0] CH_SEMI     = 8'h3B;
  localparam logic [7:0] CH_H        = 8'h48;

  typedef enum logic [2:0] {
    IDLE,
    ESC,
    CSI_ROW,
    CSI_COL,
    CLEAR,
    SCROLL_WAIT
  } state_t;

  // 1-based CSI coordinate to 0-based cursor position; 0 acts as 1, large values clamp.
  function automatic int unsigned csi_pos(input int unsigned n, input int unsigned lim);
    if (n == 0) return 0;
    else if (n >= lim) return lim - 1;
    else return n - 1;
  endfunction

endpackage

// File: rtl/term_clear_sweep.sv
// Row-major sweep over every screen cell, one address per cycle after start.
module term_clear_sweep #(
  parameter int unsigned ROWS = term_pkg::DEF_ROWS,
  parameter int unsigned COLS = term_pkg::DEF_COLS,
  parameter int unsigned X_W  = term_pkg::DEF_X_W,
  parameter int unsigned Y_W  = term_pkg::DEF_Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic [Y_W-1:0] row,
  output logic [X_W-1:0] col,
  output logic           done_c
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  logic running;

  // High while the final cell address is being presented.
  assign done_c = running && (row == Y_LAST) && (col == X_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      row     <= '0;
      col     <= '0;
    end else if (start) begin
      running <= 1'b1;
      row     <= '0;
      col     <= '0;
    end else if (running) begin
      if (col == X_LAST) begin
        col <= '0;
        if (row == Y_LAST) begin
          running <= 1'b0;
          row     <= '0;
        end else begin
          row <= row + Y_W'(1);
        end
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/term_cmd_parser.sv
// Byte interpreter for the text screen: cursor, cell writes, scroll and clear requests.
// Define TERM_CSI_EN to add the ESC [ row ; col H cursor-positioning sequence.
module term_cmd_parser
  import term_pkg::*;
#(
  parameter int unsigned COLS     = term_pkg::DEF_COLS,
  parameter int unsigned ROWS     = term_pkg::DEF_ROWS,
  parameter int unsigned X_W      = term_pkg::DEF_X_W,
  parameter int unsigned Y_W      = term_pkg::DEF_Y_W,
  parameter int unsigned TAB_STOP = term_pkg::DEF_TAB_STOP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         rx_data,
  input  logic               rx_empty,
  output logic               rd_uart,
  output logic               wr_en,
  output logic [X_W+Y_W-1:0] wr_addr,
  output logic [6:0]         wr_data,
  output logic               scroll_req,
  input  logic               scroll_ack,
  output logic [X_W-1:0]     cursor_x,
  output logic [Y_W-1:0]     cursor_y,
  output logic               busy
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);
  localparam int unsigned    TS_W   = $clog2(TAB_STOP);

  state_t         state;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;

  logic           pop_c;
  logic           sweep_start_c;
  logic           sweep_done_c;
  logic [Y_W-1:0] sweep_row;
  logic [X_W-1:0] sweep_col;
  logic [X_W:0]   tab_next_c;
  logic [X_W-1:0] tab_x_c;

  assign pop_c         = !rx_empty && (state inside {IDLE, ESC, CSI_ROW, CSI_COL});
  assign rd_uart       = pop_c;
  assign sweep_start_c = pop_c && (state == IDLE) && (rx_data == CH_FF);
  assign cursor_x      = x_q;
  assign cursor_y      = y_q;

  // Next tab stop computed one bit wider so the last stop can exceed the line before clamping.
  assign tab_next_c = (({1'b0, x_q} >> TS_W) + (X_W+1)'(1)) << TS_W;
  assign tab_x_c    = (tab_next_c > {1'b0, X_LAST}) ? X_LAST : tab_next_c[X_W-1:0];

`ifdef TERM_CSI_EN
  localparam int unsigned ACC_W = 7;

  logic [ACC_W-1:0]   row_acc;
  logic [ACC_W-1:0]   col_acc;
  logic [ACC_W-1:0]   acc_sel_c;
  logic [ACC_W+3:0]   acc_mul_c;
  logic [ACC_W-1:0]   acc_next_c;
  logic               is_digit_c;

  assign is_digit_c = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign acc_sel_c  = (state == CSI_COL) ? col_acc : row_acc;
  assign acc_mul_c  = (ACC_W+4)'(acc_sel_c) * (ACC_W+4)'(10) + (ACC_W+4)'(rx_data[3:0]);
  assign acc_next_c = (acc_mul_c > (ACC_W+4)'(127)) ? ACC_W'(127) : acc_mul_c[ACC_W-1:0];
`endif

  term_clear_sweep #(
    .ROWS(ROWS),
    .COLS(COLS),
    .X_W (X_W),
    .Y_W (Y_W)
  ) u_sweep (
    .clk   (clk),
    .rst_n (rst_n),
    .start (sweep_start_c),
    .row   (sweep_row),
    .col   (sweep_col),
    .done_c(sweep_done_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      scroll_req <= 1'b0;
      busy       <= 1'b0;
`ifdef TERM_CSI_EN
      row_acc    <= '0;
      col_acc    <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop_c) begin
            if ((rx_data >= 8'h20) && (rx_data <= 8'h7E)) begin
              wr_en   <= 1'b1;
              wr_addr <= {y_q, x_q};
              wr_data <= rx_data[6:0];
              if (x_q == X_LAST) begin
                x_q <= '0;
                if (y_q == Y_LAST) begin
                  state      <= SCROLL_WAIT;
                  scroll_req <= 1'b1;
                  busy       <= 1'b1;
                end else begin
                  y_q <= y_q + Y_W'(1);
                end
              end else begin
                x_q <= x_q + X_W'(1);
              end
            end else if (rx_data == CH_CR) begin
              x_q <= '0;
              if (y_q == Y_LAST) begin
                state      <= SCROLL_WAIT;
                scroll_req <= 1'b1;
                busy       <= 1'b1;
              end else begin
                y_q <= y_q + Y_W'(1);
              end
            end else if (rx_data == CH_BS) begin
              if (x_q != '0) begin
                x_q     <= x_q - X_W'(1);
                wr_en   <= 1'b1;
                wr_addr <= {y_q, x_q - X_W'(1)};
                wr_data <= '0;
              end
            end else if (rx_data == CH_TAB) begin
              x_q <= tab_x_c;
            end else if (rx_data == CH_FF) begin
              state <= CLEAR;
              busy  <= 1'b1;
`ifdef TERM_CSI_EN
            end else if (rx_data == CH_ESC) begin
              state <= ESC;
`endif
            end
          end
        end

        // One blank write per cycle following the sweep counter.
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= {sweep_row, sweep_col};
          wr_data <= '0;
          if (sweep_done_c) begin
            state <= IDLE;
            busy  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
          end
        end

        SCROLL_WAIT: begin
          if (scroll_ack) begin
            state      <= IDLE;
            scroll_req <= 1'b0;
            busy       <= 1'b0;
          end
        end

`ifdef TERM_CSI_EN
        ESC: begin
          if (pop_c) begin
            row_acc <= '0;
            col_acc <= '0;
            state   <= (rx_data == CH_LBRACKET) ? CSI_ROW : IDLE;
          end
        end

        CSI_ROW, CSI_COL: begin
          if (pop_c) begin
            if (is_digit_c) begin
              if (state == CSI_ROW) row_acc <= acc_next_c;
              else                  col_acc <= acc_next_c;
            end else if ((rx_data == CH_SEMI) && (state == CSI_ROW)) begin
              state <= CSI_COL;
            end else if (rx_data == CH_H) begin
              x_q   <= X_W'(csi_pos(32'(col_acc), COLS));
              y_q   <= Y_W'(csi_pos(32'(row_acc), ROWS));
              state <= IDLE;
            end else begin
              state <= IDLE;
            end
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule
